// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher definitions: FSM states, round counts, key-size
// encodings, inverse S-box table and GF(2^8) helpers (poly x^8+x^4+x^3+x+1).
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_e;

  localparam int unsigned NRW = 4;
  localparam logic [NRW-1:0] NR_128 = 4'd10;
  localparam logic [NRW-1:0] NR_192 = 4'd12;
  localparam logic [NRW-1:0] NR_256 = 4'd14;

  localparam logic [1:0] SIZE_128 = 2'b00;
  localparam logic [1:0] SIZE_192 = 2'b01;
  localparam logic [1:0] SIZE_256 = 2'b10;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Round count for a key-size code; the reserved code falls back to AES-128.
  function automatic logic [NRW-1:0] nr_from_size(input logic [1:0] sz);
    case (sz)
      SIZE_192: return NR_192;
      SIZE_256: return NR_256;
      default:  return NR_128;
    endcase
  endfunction

  // Multiply by x modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply by shift-and-add.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // InvMixColumns on one column, row 0 in the top byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  // InvMixColumns on the full column-major state.
  function automatic logic [127:0] inv_mix_cols(input logic [127:0] s);
    logic [127:0] r;
    for (int j = 0; j < 4; j++) r[127-32*j -: 32] = inv_mix_col(s[127-32*j -: 32]);
    return r;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Single-byte AES inverse S-box lookup.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout_c
);

  // Table lookup from the shared inverse S-box.
  assign dout_c = INV_SBOX[din];

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher, one round per clock, AES-128/192/256.
// Optional AES_INV_KEYLATCH_EN: copy the round keys at accept so the caller
// may change key_sched while a block is in flight.
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int unsigned NR_MAX = 14
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [127:0]              in,
  input  logic [1:0]                size,
  input  logic [128*(NR_MAX+1)-1:0] key_sched,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [127:0]              out
);

  fsm_e           fsm;
  logic [127:0]   st;
  logic [NRW-1:0] rcnt;
  logic [NRW-1:0] nr;
  logic [NRW-1:0] nr_in;
  logic [NRW-1:0] rk_idx;
  logic           accept;
  logic [127:0]   rk_in [NR_MAX+1];
  logic [127:0]   rk_rnd;
  logic [127:0]   sub_c;
  logic [127:0]   ark_c;
  logic [127:0]   imc_c;

  assign nr_in  = nr_from_size(size);
  assign accept = (fsm == IDLE) && in_valid && in_ready;
  // Never index past the schedule of the block in flight.
  assign rk_idx = (rcnt > nr) ? nr : rcnt;

  // Slice the flat schedule into round keys.
  for (genvar g = 0; g <= NR_MAX; g++) begin : g_rk
    assign rk_in[g] = key_sched[128*g +: 128];
  end

  // InvShiftRows is pure wiring into the 16 inverse S-boxes.
  for (genvar g = 0; g < 16; g++) begin : g_sub
    localparam int unsigned ROW = g % 4;
    localparam int unsigned SRC = ROW + 4 * (((g / 4) + 4 - ROW) % 4);
    aes_inv_sbox u_sbox (
      .din    (st[127-8*SRC -: 8]),
      .dout_c (sub_c[127-8*g -: 8])
    );
  end

`ifdef AES_INV_KEYLATCH_EN
  logic [127:0] key_q [NR_MAX+1];

  // Private copy of the round keys, captured when a block is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i <= NR_MAX; i++) key_q[i] <= '0;
    end else if (accept) begin
      for (int unsigned i = 0; i <= NR_MAX; i++) key_q[i] <= rk_in[i];
    end
  end

  assign rk_rnd = key_q[rk_idx];
`else
  assign rk_rnd = rk_in[rk_idx];
`endif

  assign ark_c = sub_c ^ rk_rnd;
  assign imc_c = inv_mix_cols(ark_c);

  // Control FSM and datapath registers; all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      st        <= '0;
      rcnt      <= '0;
      nr        <= NR_128;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (accept) begin
            nr       <= nr_in;
            st       <= in ^ rk_in[nr_in];
            rcnt     <= nr_in - 4'd1;
            in_ready <= 1'b0;
            fsm      <= ROUND;
          end else begin
            in_ready <= 1'b1;
          end
        end
        ROUND: begin
          if (rcnt == 4'd0) begin
            st        <= ark_c;
            out       <= ark_c;
            out_valid <= 1'b1;
            fsm       <= DONE;
          end else begin
            st   <= imc_c;
            rcnt <= rcnt - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out       <= '0;
            in_ready  <= 1'b1;
            fsm       <= IDLE;
          end
        end
        default: begin
          fsm      <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter using FIPS-197 vectors.
module tb_aes_inv_cipher_iter;

  localparam int unsigned NR_MAX = 14;
  localparam int unsigned KSW    = 128 * (NR_MAX + 1);
`ifdef AES_INV_KEYLATCH_EN
  localparam bit CORRUPT = 1'b1;
`else
  localparam bit CORRUPT = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [127:0]   in_blk = '0;
  logic [1:0]     size = 2'b00;
  logic [KSW-1:0] key_sched = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [127:0]   out_blk;

  int vec  = 0;
  int errs = 0;

  always #5 clk = ~clk;

  aes_inv_cipher_iter #(.NR_MAX(NR_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_blk),
    .size      (size),
    .key_sched (key_sched),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_blk)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box from its algebraic definition: inverse then affine map.
  function automatic logic [7:0] sbox_f(input logic [7:0] b);
    logic [7:0] v;
    v = 8'h00;
    if (b != 8'h00) begin
      v = 8'h01;
      for (int i = 0; i < 254; i++) v = gm(v, b);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_f(w[31:24]), sbox_f(w[23:16]), sbox_f(w[15:8]), sbox_f(w[7:0])};
  endfunction

  // Standard key expansion; key is left-aligned in 256 bits.
  function automatic logic [KSW-1:0] expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0]    w [60];
    logic [31:0]    t;
    logic [7:0]     rc;
    logic [KSW-1:0] ks;
    ks = '0;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) ks[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ks;
  endfunction

  // One block: accept, measure latency, hold out for bp cycles, handshake.
  task automatic run_block(input string tag, input logic [127:0] ct, input logic [1:0] sz,
                           input logic [KSW-1:0] ks, input logic [127:0] pt, input int nr, input int bp);
    int cyc;
    int busy_rdy;
    logic [127:0] held;
    @(posedge clk); #1;
    in_blk = ct; size = sz; key_sched = ks; in_valid = 1'b1;
    @(negedge clk);
    chk({tag, " in_ready before accept"}, 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_blk   = {$urandom, $urandom, $urandom, $urandom};
    size     = 2'($urandom);
    if (CORRUPT) key_sched = ~ks;
    cyc = 1;
    busy_rdy = 0;
    @(negedge clk);
    while (!out_valid && cyc < 40) begin
      if (in_ready) busy_rdy++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, 128'(cyc), 128'(nr + 1));
    chk({tag, " in_ready while busy"}, 128'(busy_rdy), 128'd0);
    chk({tag, " plaintext"}, out_blk, pt);
    held = out_blk;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk({tag, " out held"}, out_blk, held);
      chk({tag, " in_ready/out_valid held"}, 128'({in_ready, out_valid}), 128'b01);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, " in_ready in handshake cycle"}, 128'(in_ready), 128'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, " out_valid after handshake"}, 128'(out_valid), 128'd0);
    chk({tag, " out zero after handshake"}, out_blk, 128'd0);
    chk({tag, " in_ready after handshake"}, 128'(in_ready), 128'd1);
  endtask

  initial begin
    logic [KSW-1:0] ks128;
    logic [KSW-1:0] ks192;
    logic [KSW-1:0] ks256;
    int ov_cnt;
    ks128 = expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10);
    ks192 = expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6, 12);
    ks256 = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);

    // Reset values while rst_n is low.
    @(negedge clk);
    chk("reset in_ready", 128'(in_ready), 128'd0);
    chk("reset out_valid", 128'(out_valid), 128'd0);
    chk("reset out", out_blk, 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready before first edge", 128'(in_ready), 128'd0);
    @(negedge clk);
    chk("in_ready after first edge", 128'(in_ready), 128'd1);

    run_block("aes128", 128'h3925841d02dc09fbdc118597196a0b32, 2'b00, ks128,
              128'h3243f6a8885a308d313198a2e0370734, 10, 5);
    run_block("aes192", 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 2'b01, ks192,
              128'h00112233445566778899aabbccddeeff, 12, 0);
    run_block("aes256", 128'h8ea2b7ca516745bfeafc49904b496089, 2'b10, ks256,
              128'h00112233445566778899aabbccddeeff, 14, 1);
    run_block("size11", 128'h3925841d02dc09fbdc118597196a0b32, 2'b11, ks128,
              128'h3243f6a8885a308d313198a2e0370734, 10, 0);

    // Reset in the middle of an AES-256 block.
    @(posedge clk); #1;
    in_blk = 128'h8ea2b7ca516745bfeafc49904b496089; size = 2'b10; key_sched = ks256; in_valid = 1'b1;
    @(negedge clk);
    chk("midrst in_ready before accept", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid in reset", 128'(out_valid), 128'd0);
    chk("midrst in_ready in reset", 128'(in_ready), 128'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ov_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) ov_cnt++;
    end
    chk("midrst no out_valid", 128'(ov_cnt), 128'd0);
    chk("midrst in_ready back", 128'(in_ready), 128'd1);

    run_block("post-reset aes128", 128'h3925841d02dc09fbdc118597196a0b32, 2'b00, ks128,
              128'h3243f6a8885a308d313198a2e0370734, 10, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
